// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory port. Accepts byte,
// half-word and word loads/stores, performs sub-word stores as a
// read-modify-write of the whole word, and returns lane-extracted,
// sign/zero-extended load data with a one-cycle response pulse.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [15:0] lat_wdata;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic        misaligned_q;

    logic        req_misaligned;
    logic [1:0]  lane;
    logic [4:0]  byte_base;
    logic [4:0]  half_base;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_result;
    logic [31:0] merge_result;

    assign lane      = lat_addr[1:0];
    assign byte_base = {lane, 3'b000};
    assign half_base = {lat_addr[1], 4'b0000};

    assign req_ready        = (state == IDLE);
    assign resp_valid       = (state == RESP);
    assign mem_write_enable = (state == WRITE);
    assign resp_rdata       = rdata_q;
    assign resp_misaligned  = misaligned_q;
    assign mem_addr         = {2'b00, lat_addr[31:2]};
    assign mem_write_data   = merge_q;

    // Flag incoming requests whose address is not naturally aligned to their size.
    always_comb begin
        req_misaligned = 1'b0;
        case (req_size)
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = req_addr[0];
            default: req_misaligned = (req_addr[1:0] != 2'b00);
        endcase
    end

    // Extract the addressed lane from the read word and extend it to 32 bits.
    always_comb begin
        load_byte   = mem_read_data[byte_base +: 8];
        load_half   = mem_read_data[half_base +: 16];
        load_result = mem_read_data;
        case (lat_size)
            2'b00:   load_result = lat_unsigned ? {24'd0, load_byte}
                                                : {{24{load_byte[7]}}, load_byte};
            2'b01:   load_result = lat_unsigned ? {16'd0, load_half}
                                                : {{16{load_half[15]}}, load_half};
            default: load_result = mem_read_data;
        endcase
    end

    // Replace only the addressed lane of the read word with the store data.
    always_comb begin
        merge_result = mem_read_data;
        case (lat_size)
            2'b00:   merge_result[byte_base +: 8]  = lat_wdata[7:0];
            2'b01:   merge_result[half_base +: 16] = lat_wdata[15:0];
            default: merge_result = mem_read_data;
        endcase
    end

    // Pick the next state from the current state and, in IDLE, the request type.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_misaligned)
                        next_state = RESP;
                    else if (!req_write)
                        next_state = LOAD;
                    else if (req_size[1])
                        next_state = WRITE;
                    else
                        next_state = RMW_RD;
                end
            end
            LOAD:    next_state = RESP;
            RMW_RD:  next_state = WRITE;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Request latches, merge register and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 16'd0;
            merge_q      <= 32'd0;
            rdata_q      <= 32'd0;
            misaligned_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_addr     <= req_addr;
                        lat_wdata    <= req_wdata[15:0];
                        misaligned_q <= req_misaligned;
                        if (req_misaligned)
                            rdata_q <= 32'd0;
                        if (req_write && req_size[1] && !req_misaligned)
                            merge_q <= req_wdata;
                    end
                end
                LOAD:    rdata_q      <= load_result;
                RMW_RD:  merge_q      <= merge_result;
                WRITE:   rdata_q      <= 32'd0;
                RESP:    misaligned_q <= 1'b0;
                default: misaligned_q <= 1'b0;
            endcase
        end
    end

endmodule
